// File: rtl/uart_arb_pkg.sv
// Shared types and ASCII helpers for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    SRC_CPU  = 1'b0,
    SRC_DUMP = 1'b1
  } arb_src_e;

  localparam logic [7:0] CHR_0  = 8'h30;
  localparam logic [7:0] CHR_A  = 8'h41;
  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;

  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return CHR_0 + {4'h0, nib};
    end
    return CHR_A + {4'h0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_char_fifo.sv
// Synchronous character FIFO with combinational read of the head entry.
module uart_char_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic [7:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between the CPU char stream and a hex-dump engine.
// Optional macro UART_ARB_DROPCNT_EN enables the saturating dropped-char counter.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DUMP_CRLF  = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  cpu_char,
  input  logic        cpu_valid,
  input  logic        dump_req,
  input  logic [31:0] dump_data,
  output logic        dump_busy,
  output logic        fifo_full,
  input  logic        uart_ready,
  output logic        uart_send,
  output logic [7:0]  uart_data,
  output logic [15:0] drop_cnt
);

  localparam logic [3:0] DUMP_LEN = (DUMP_CRLF != 0) ? 4'd10 : 4'd8;

  logic       fifo_empty;
  logic       fifo_full_w;
  logic       fifo_pop;
  logic [7:0] fifo_dout;

  arb_state_e  state_q;
  arb_src_e    src_q;
  arb_src_e    rr_last_q;
  logic [31:0] dump_sr_q;
  logic [3:0]  dump_idx_q;
  logic        dump_busy_q;
  logic        uart_send_q;
  logic [7:0]  uart_data_q;

  logic        cpu_pend;
  logic        dump_pend;
  logic        grant_cpu;
  logic        grant_dump;
  logic [7:0]  dump_char;

  uart_char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (cpu_valid),
    .pop   (fifo_pop),
    .din   (cpu_char),
    .full  (fifo_full_w),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  assign fifo_full = fifo_full_w;
  assign dump_busy = dump_busy_q;
  assign uart_send = uart_send_q;
  assign uart_data = uart_data_q;

  assign cpu_pend  = !fifo_empty;
  assign dump_pend = dump_busy_q && (dump_idx_q == 4'd0);

  // The shift register always presents the next nibble in its top four bits.
  always_comb begin
    dump_char = CHR_LF;
    if (dump_idx_q < 4'd8) begin
      dump_char = nib2ascii(dump_sr_q[31:28]);
    end else if (dump_idx_q == 4'd8) begin
      dump_char = CHR_CR;
    end
  end

  always_comb begin
    grant_cpu  = 1'b0;
    grant_dump = 1'b0;
    if (state_q == IDLE && uart_ready) begin
      if (cpu_pend && dump_pend) begin
        if (rr_last_q == SRC_DUMP) grant_cpu = 1'b1;
        else                       grant_dump = 1'b1;
      end else if (cpu_pend) begin
        grant_cpu = 1'b1;
      end else if (dump_pend) begin
        grant_dump = 1'b1;
      end
    end
  end

  assign fifo_pop = grant_cpu;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      src_q       <= SRC_CPU;
      rr_last_q   <= SRC_DUMP;
      dump_sr_q   <= '0;
      dump_idx_q  <= '0;
      dump_busy_q <= 1'b0;
      uart_send_q <= 1'b0;
      uart_data_q <= '0;
    end else begin
      // Capture only ever happens while idle, so it never collides with emission below.
      if (dump_req && !dump_busy_q) begin
        dump_sr_q   <= dump_data;
        dump_busy_q <= 1'b1;
        dump_idx_q  <= '0;
      end
      case (state_q)
        IDLE: begin
          if (grant_cpu) begin
            uart_data_q <= fifo_dout;
            uart_send_q <= 1'b1;
            src_q       <= SRC_CPU;
            rr_last_q   <= SRC_CPU;
            state_q     <= SEND;
          end else if (grant_dump) begin
            uart_data_q <= dump_char;
            uart_send_q <= 1'b1;
            src_q       <= SRC_DUMP;
            rr_last_q   <= SRC_DUMP;
            dump_sr_q   <= dump_sr_q << 4;
            dump_idx_q  <= dump_idx_q + 4'd1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (!uart_ready) begin
            uart_send_q <= 1'b0;
            state_q     <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (uart_ready) begin
            if (src_q == SRC_DUMP && dump_idx_q < DUMP_LEN) begin
              uart_data_q <= dump_char;
              uart_send_q <= 1'b1;
              dump_sr_q   <= dump_sr_q << 4;
              dump_idx_q  <= dump_idx_q + 4'd1;
              state_q     <= SEND;
            end else begin
              if (src_q == SRC_DUMP) begin
                dump_busy_q <= 1'b0;
                dump_idx_q  <= '0;
              end
              state_q <= IDLE;
            end
          end
        end
        default: begin
          uart_send_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_ARB_DROPCNT_EN
  logic [15:0] drop_cnt_q;

  // A char offered while full is lost even if the arbiter pops in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt_q <= '0;
    end else if (cpu_valid && fifo_full_w && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural UART transmitter model.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_DROPCNT_EN
  localparam logic [15:0] EXP_DROP = 16'd4;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  cpu_char = 8'h00;
  logic        cpu_valid = 1'b0;
  logic        dump_req = 1'b0;
  logic [31:0] dump_data = 32'h0;
  logic        dump_busy;
  logic        fifo_full;
  logic        uart_ready = 1'b1;
  logic        uart_send;
  logic [7:0]  uart_data;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad = 0;
  int nsent = 0;
  logic [7:0] expq[$];
  logic       hold = 1'b0;
  int         ucnt = 0;
  logic       prev_send = 1'b0;
  logic [7:0] held_data = 8'h00;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .FIFO_DEPTH (16),
    .DUMP_CRLF  (1)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cpu_char   (cpu_char),
    .cpu_valid  (cpu_valid),
    .dump_req   (dump_req),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .fifo_full  (fifo_full),
    .uart_ready (uart_ready),
    .uart_send  (uart_send),
    .uart_data  (uart_data),
    .drop_cnt   (drop_cnt)
  );

  // Transmitter model: READY drops the cycle after SEND is seen, returns 10 cycles later.
  always @(posedge clk) begin
    if (hold) begin
      uart_ready <= 1'b0;
    end else if (ucnt > 0) begin
      ucnt <= ucnt - 1;
      if (ucnt == 1) uart_ready <= 1'b1;
    end else if (uart_send && uart_ready) begin
      uart_ready <= 1'b0;
      ucnt <= 10;
    end else begin
      uart_ready <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every rising SEND is one transaction checked against the scoreboard.
  always @(negedge clk) begin
    if (uart_send && !prev_send) begin
      nsent++;
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got=%02h expected=none", uart_data);
      end else begin
        logic [7:0] e;
        e = expq.pop_front();
        $display("tx byte %0d: data=%02h expected=%02h", nsent, uart_data, e);
        check("tx_byte", {24'h0, uart_data}, {24'h0, e});
      end
      held_data = uart_data;
    end else if (uart_send && prev_send) begin
      check("data_stable", {24'h0, uart_data}, {24'h0, held_data});
    end
    prev_send = uart_send;
  end

  task automatic push_msg(input string s, input bit crlf);
    for (int i = 0; i < s.len(); i++) expq.push_back(s[i]);
    if (crlf) begin
      expq.push_back(8'h0D);
      expq.push_back(8'h0A);
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!(expq.size() == 0 && !uart_send && uart_ready && !dump_busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k >= 3000) begin
      bad++;
      $display("FAIL %s_timeout: pending=%0d expected=0", name, expq.size());
      expq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_sent(input string name, input int target);
    int k;
    k = 0;
    while (nsent < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k >= 3000) begin
      bad++;
      $display("FAIL %s_timeout: sent=%0d expected=%0d", name, nsent, target);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_send"}, {31'h0, uart_send}, 32'h0);
    check({tag, "_data"}, {24'h0, uart_data}, 32'h0);
    check({tag, "_busy"}, {31'h0, dump_busy}, 32'h0);
    check({tag, "_full"}, {31'h0, fifo_full}, 32'h0);
    check({tag, "_drop"}, {16'h0, drop_cnt}, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic cpu_burst(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cpu_valid = 1'b1;
      cpu_char = first + 8'(i);
    end
    @(negedge clk);
    cpu_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // 1: single char latency
    cpu_valid = 1'b1;
    cpu_char = 8'h41;
    expq.push_back(8'h41);
    @(posedge clk);
    #1;
    cpu_valid = 1'b0;
    check("lat_edge_n", {31'h0, uart_send}, 32'h0);
    @(posedge clk);
    #1;
    check("lat_edge_n1_send", {31'h0, uart_send}, 32'h1);
    check("lat_edge_n1_data", {24'h0, uart_data}, 32'h41);
    wait_idle("single");
    check("single_full", {31'h0, fifo_full}, 32'h0);

    // 2: dump with a request arriving mid-message
    base = nsent;
    @(negedge clk);
    dump_req = 1'b1;
    dump_data = 32'hDEADBEEF;
    push_msg("DEADBEEF", 1'b1);
    @(posedge clk);
    #1;
    dump_req = 1'b0;
    check("dump_busy_set", {31'h0, dump_busy}, 32'h1);
    wait_sent("dump_mid", base + 3);
    @(negedge clk);
    dump_req = 1'b1;
    dump_data = 32'h12345678;
    @(negedge clk);
    dump_req = 1'b0;
    wait_sent("dump_last", base + 10);
    check("dump_busy_last", {31'h0, dump_busy}, 32'h1);
    wait_idle("dump");
    check("dump_busy_clr", {31'h0, dump_busy}, 32'h0);

    // 3: contention from reset: CPU wins first tie, dump is never interleaved
    do_reset();
    cpu_valid = 1'b1;
    cpu_char = 8'h31;
    dump_req = 1'b1;
    dump_data = 32'h0123A5F9;
    expq.push_back(8'h31);
    push_msg("0123A5F9", 1'b1);
    expq.push_back(8'h32);
    expq.push_back(8'h33);
    @(negedge clk);
    dump_req = 1'b0;
    cpu_char = 8'h32;
    @(negedge clk);
    cpu_char = 8'h33;
    @(negedge clk);
    cpu_valid = 1'b0;
    wait_idle("contend");

    // 4: overflow with READY held low
    hold = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 16; i++) expq.push_back(8'h60 + 8'(i));
    cpu_burst(8'h60, 20);
    check("ovf_full", {31'h0, fifo_full}, 32'h1);
    check("ovf_drop", {16'h0, drop_cnt}, {16'h0, EXP_DROP});
    check("ovf_nosend", {31'h0, uart_send}, 32'h0);
    hold = 1'b0;
    wait_idle("overflow");
    check("ovf_full_clr", {31'h0, fifo_full}, 32'h0);

    // 5: reset while a dump byte is in SEND
    base = nsent;
    @(negedge clk);
    dump_req = 1'b1;
    dump_data = 32'hCAFEF00D;
    push_msg("CAFEF00D", 1'b1);
    @(negedge clk);
    dump_req = 1'b0;
    wait_sent("rst_mid", base + 3);
    check("rst_in_send", {31'h0, uart_send}, 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_async_send", {31'h0, uart_send}, 32'h0);
    check("rst_async_busy", {31'h0, dump_busy}, 32'h0);
    expq.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (200) @(negedge clk);
    check("rst_no_residual", nsent, base + 3);
    check("rst_drop_clr", {16'h0, drop_cnt}, 32'h0);

    // 6: 40 chars through the FIFO so both pointers wrap
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 8; i++) expq.push_back(8'(b * 8 + i));
      cpu_burst(8'(b * 8), 8);
      wait_idle("wrap");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
